// File: rtl/alu_share_arbiter_pkg.sv
// Shared encodings for the shared-ALU arbiter: ALU op codes and FSM states.
package alu_share_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int ID_W = 3;

  function automatic logic op_is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu32_core.sv
// Combinational W-bit AND/OR/ADD/SUB unit. SUB is A + ~B + 1, so cout=1
// means no borrow; cout is forced to 0 for the logic ops.
module alu32_core
  import alu_share_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  op_e          op_i,
  output logic [W-1:0] result_o,
  output logic         cout_o
);

  logic         sub;
  logic [W-1:0] b_eff;
  logic [W-1:0] sum_v;
  logic         carry_out;

  assign sub   = (op_i == OP_SUB);
  assign b_eff = b_i ^ {W{sub}};

  // Ripple chain of full-adder cells; the SUB carry-in supplies the +1.
  always_comb begin
    logic carry;
    carry = sub;
    sum_v = '0;
    for (int i = 0; i < W; i++) begin
      sum_v[i] = a_i[i] ^ b_eff[i] ^ carry;
      carry    = (a_i[i] & b_eff[i]) | (carry & (a_i[i] ^ b_eff[i]));
    end
    carry_out = carry;
  end

  // Result mux over the four operations.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      default: result_o = sum_v;
    endcase
    cout_o = op_is_arith(op_i) ? carry_out : 1'b0;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
// Optional macro ALU_ARB_FAST_EN: drops the EXEC state and computes the
// result straight from the granted requester's inputs on the grant edge.
//
// state | meaning
// IDLE  | searching for a valid requester, req_ready driven here only
// EXEC  | operands registered, result being computed and registered
// RESP  | result held on the response port until rsp_ready
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_cout
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q;
  logic [W-1:0]    data_q;
  logic            cout_q;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [7:0]      vld_ext;
  logic [7:0]      rdy_ext;

  op_e             alu_op;
  logic [W-1:0]    alu_a, alu_b, alu_res;
  logic            alu_cout;

  // Grant search: first valid index upward from ptr+1, wrapping modulo NREQ.
  always_comb begin
    vld_ext             = '0;
    vld_ext[NREQ-1:0]   = req_valid;
    gnt_found           = 1'b0;
    gnt_idx             = '0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [ID_W-1:0] cand;
      cand = ID_W'((int'(ptr_q) + k) % NREQ);
      if (!gnt_found && vld_ext[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Ready is only ever offered in IDLE, to the single granted requester.
  always_comb begin
    rdy_ext = '0;
    if (state_q == ST_IDLE && gnt_found) rdy_ext[gnt_idx] = 1'b1;
    req_ready = rdy_ext[NREQ-1:0];
  end

`ifdef ALU_ARB_FAST_EN
  // ALU fed straight from the requester being granted this cycle.
  always_comb begin
    alu_op = op_e'(req_op[2*gnt_idx +: 2]);
    alu_a  = req_a[W*gnt_idx +: W];
    alu_b  = req_b[W*gnt_idx +: W];
  end
`else
  op_e          op_q;
  logic [W-1:0] a_q, b_q;

  // Operand capture on the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_AND;
      a_q  <= '0;
      b_q  <= '0;
    end else if (state_q == ST_IDLE && gnt_found) begin
      op_q <= op_e'(req_op[2*gnt_idx +: 2]);
      a_q  <= req_a[W*gnt_idx +: W];
      b_q  <= req_b[W*gnt_idx +: W];
    end
  end

  // ALU fed from the registered operands.
  always_comb begin
    alu_op = op_q;
    alu_a  = a_q;
    alu_b  = b_q;
  end
`endif

  alu32_core #(.W(W)) u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_res),
    .cout_o   (alu_cout)
  );

  // State and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= ID_W'(NREQ - 1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic; the pointer only moves on a completed response.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
`ifdef ALU_ARB_FAST_EN
        if (gnt_found) state_d = ST_RESP;
`else
        if (gnt_found) state_d = ST_EXEC;
`endif
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          ptr_d   = id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response registers: id on grant, result on grant (fast) or in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q   <= '0;
      data_q <= '0;
      cout_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && gnt_found) id_q <= gnt_idx;
`ifdef ALU_ARB_FAST_EN
      if (state_q == ST_IDLE && gnt_found) begin
`else
      if (state_q == ST_EXEC) begin
`endif
        data_q <= alu_res;
        cout_q <= alu_cout;
      end
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed + randomized bench for alu_share_arbiter with a behavioural
// arbitration/ALU reference model.
module tb_alu_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_cout;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout)
  );

  int tests = 0;
  int fails = 0;
  int rr_ptr;

  logic        vld [NREQ];
  logic [1:0]  op  [NREQ];
  logic [31:0] oa  [NREQ];
  logic [31:0] ob  [NREQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]      = vld[i];
      req_op[2*i +: 2]  = op[i];
      req_a[W*i +: W]   = oa[i];
      req_b[W*i +: W]   = ob[i];
    end
  endtask

  task automatic new_req(input int i);
    op[i] = 2'($urandom_range(0, 3));
    oa[i] = $urandom;
    ob[i] = $urandom;
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    vld[i] = 1'b1;
    op[i]  = o;
    oa[i]  = a;
    ob[i]  = b;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) vld[i] = 1'b0;
  endtask

  // Next grant: first valid index after the last-served one, wrapping.
  function automatic int model_grant();
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (rr_ptr + k) % NREQ;
      if (vld[idx]) return idx;
    end
    return -1;
  endfunction

  // {cout, data} computed from plain arithmetic.
  function automatic logic [32:0] ref_alu(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      2'd0:    return {1'b0, a & b};
      2'd1:    return {1'b0, a | b};
      2'd2:    return {1'b0, a} + {1'b0, b};
      default: return {(a >= b) ? 1'b1 : 1'b0, a - b};
    endcase
  endfunction

  // One full grant/response transaction. mode: 0 drop granted request,
  // 1 keep it valid with new operands, 2 random.
  task automatic txn(input int bp, input int mode, output int got_id);
    int          waited;
    int          g;
    logic [32:0] exp;
    got_id    = -1;
    rsp_ready = 1'b0;
    drive();
    #1;
    waited = 0;
    while (req_ready == '0 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    g = model_grant();
    check("grant_onehot", 64'(req_ready), (g < 0) ? 64'd0 : 64'(1 << g));
    if (mode == 1) check("grant_spacing", 64'(waited), 64'd0);
    if (g < 0 || req_ready == '0) return;
    exp = ref_alu(op[g], oa[g], ob[g]);
    @(posedge clk);
    case (mode)
      0: vld[g] = 1'b0;
      1: new_req(g);
      default: begin
        vld[g] = 1'($urandom_range(0, 1));
        new_req(g);
      end
    endcase
    @(negedge clk);
    drive();
    #1;
`ifndef ALU_ARB_FAST_EN
    check("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    check("exec_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
`endif
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_id", 64'(rsp_id), 64'(g));
    check("rsp_data", 64'(rsp_data), 64'(exp[31:0]));
    check("rsp_cout", 64'(rsp_cout), 64'(exp[32]));
    got_id = int'(rsp_id);
    for (int c = 0; c < bp; c++) begin
      @(negedge clk);
      #1;
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_id", 64'(rsp_id), 64'(g));
      check("hold_data", 64'(rsp_data), 64'(exp[31:0]));
      check("hold_no_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    rr_ptr = g;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("rsp_drop", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int id;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    rr_ptr    = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 1'b0;
      op[i]  = 2'd0;
      oa[i]  = '0;
      ob[i]  = '0;
    end
    drive();
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    rst_n = 1'b1;

    // Round-robin with every requester continuously valid.
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 1'b1;
      new_req(i);
    end
    for (int k = 0; k < 5; k++) begin
      txn(0, 1, id);
      check("rr_order", 64'(id), 64'(exp_order[k]));
    end
    clear_all();
    drive();
    @(negedge clk);

    // Directed arithmetic and logic cases on requester 0.
    set_req(0, 2'd2, 32'h0000_0005, 32'h0000_0003); txn(0, 0, id);
    set_req(0, 2'd2, 32'hFFFF_FFFF, 32'h0000_0001); txn(0, 0, id);
    set_req(0, 2'd3, 32'h0000_0003, 32'h0000_0005); txn(0, 0, id);
    set_req(0, 2'd3, 32'h0000_0005, 32'h0000_0005); txn(0, 0, id);
    set_req(0, 2'd0, 32'h0000_A5A5, 32'h0000_5A5A); txn(0, 0, id);
    set_req(0, 2'd1, 32'h0000_A5A5, 32'h0000_5A5A); txn(0, 0, id);

    // Backpressure: ten cycles of rsp_ready low with another requester waiting.
    set_req(1, 2'd2, $urandom, $urandom);
    set_req(2, 2'd3, $urandom, $urandom);
    txn(10, 0, id);

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      int any;
      any = 0;
      for (int i = 0; i < NREQ; i++) if (vld[i]) any = 1;
      if (any == 0) begin
        int r;
        r = $urandom_range(0, NREQ - 1);
        vld[r] = 1'b1;
        new_req(r);
      end
      txn($urandom_range(0, 2), 2, id);
    end

    // Reset while an operation is in EXEC.
    clear_all();
    drive();
    @(negedge clk);
    set_req(3, 2'd2, 32'h1234_5678, 32'h1111_1111);
    drive();
    #1;
    for (int w = 0; w < 20 && req_ready == '0; w++) begin
      @(negedge clk);
      #1;
    end
    check("rst_test_grant", 64'(req_ready), 64'(1 << 3));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    clear_all();
    drive();
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_id", 64'(rsp_id), 64'd0);
    check("midrst_rsp_data", 64'(rsp_data), 64'd0);
    check("midrst_rsp_cout", 64'(rsp_cout), 64'd0);
    rr_ptr = NREQ - 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      check("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
    end

    // Recovery after reset.
    set_req(1, 2'd3, 32'h0000_0010, 32'h0000_0001);
    txn(1, 0, id);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
